// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: WIDTH-bit operands are added LSB-first through one full-adder
// slice built from two half adders, with a start/done handshake around it.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s1;
  logic             c1;
  logic             bit_sum;
  logic             c2;
  logic             bit_carry;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  // Full-adder slice from two half adders on the current LSBs and running carry
  always_comb begin
    s1        = opa[0] ^ opb[0];
    c1        = opa[0] & opb[0];
    bit_sum   = s1 ^ carry;
    c2        = s1 & carry;
    bit_carry = c1 | c2;
  end

  // New result bit enters at the MSB; the extended shift also covers WIDTH==1
  always_comb begin
    acc_ext  = {bit_sum, acc};
    acc_next = acc_ext[WIDTH:1];
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for acceptance, giving back-to-back adds
        IDLE, DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= bit_carry;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum   <= acc_next;
            cout  <= bit_carry;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
